// File: rtl/gpu_host_port.sv
// gpu_host_port: turns level host strobes into single RAM write/read accesses.
// Each strobe's rising edge is one request. One pending slot absorbs a request
// that arrives while an access is in flight; further ones are dropped.
// Optional feature: define GPU_HOST_PORT_ERR_CNT_EN for the saturating err_count.
module gpu_host_port #(
  parameter int unsigned MEM_SIZE_BITS = 15,
  parameter int unsigned RAM_LATENCY   = 2
) (
  input  logic                     GPU_CLK,
  input  logic                     reset,
  input  logic                     host_wr_ena,
  input  logic                     host_rd_req,
  input  logic [19:0]              host_addr,
  input  logic [7:0]               host_wdata,
  output logic [7:0]               host_rdata,
  output logic                     host_rd_rdy,
  output logic [MEM_SIZE_BITS-1:0] ram_addr,
  output logic [7:0]               ram_wdata,
  output logic                     ram_wena,
  input  logic [7:0]               ram_rdata,
  output logic                     busy,
  output logic [7:0]               err_count
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DONE} state_t;

  state_t                   state, state_nx;
  logic                     wr_q, rd_q, wr_blk, rd_blk, wr_req, rd_req;
  logic                     pend_valid, pend_wr, pend_valid_nx, pend_wr_nx;
  logic [19:0]              pend_addr, pend_addr_nx;
  logic [7:0]               pend_data, pend_data_nx;
  logic [2:0]               wait_cnt, wait_cnt_nx;
  logic                     cur_oor, cur_oor_nx;
  logic [MEM_SIZE_BITS-1:0] ram_addr_nx;
  logic [7:0]               ram_wdata_nx;
  logic                     ram_wena_nx;
  logic [7:0]               rdata_q, rd_value;
  logic                     svc, svc_wr, svc_ok, slot_free, wr_new, rd_new;
  logic [19:0]              svc_addr;
  logic [7:0]               svc_data;
`ifdef GPU_HOST_PORT_ERR_CNT_EN
  logic                     addr_ok;
  logic [1:0]               err_inc;
  logic [8:0]               err_sum;
`endif

  function automatic logic in_range(input logic [19:0] a);
    return (a >> MEM_SIZE_BITS) == 20'd0;
  endfunction

  // Strobe edge registers. The *_blk flags remember a strobe that was already
  // high in the last reset cycle and mask it until it has gone low once.
  always_ff @(posedge GPU_CLK) begin
    if (reset) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      wr_blk <= host_wr_ena;
      rd_blk <= host_rd_req;
    end else begin
      wr_q   <= host_wr_ena;
      rd_q   <= host_rd_req;
      wr_blk <= wr_blk & host_wr_ena;
      rd_blk <= rd_blk & host_rd_req;
    end
  end

  assign wr_req = host_wr_ena & ~wr_q & ~wr_blk;
  assign rd_req = host_rd_req & ~rd_q & ~rd_blk;

  // FSM state register.
  always_ff @(posedge GPU_CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state, access launch and pending-slot/drop decisions.
  always_comb begin
    state_nx      = state;
    pend_valid_nx = pend_valid;
    pend_wr_nx    = pend_wr;
    pend_addr_nx  = pend_addr;
    pend_data_nx  = pend_data;
    wait_cnt_nx   = wait_cnt;
    cur_oor_nx    = cur_oor;
    ram_addr_nx   = ram_addr;
    ram_wdata_nx  = ram_wdata;
    ram_wena_nx   = 1'b0;
    slot_free     = !pend_valid;
    svc           = 1'b0;
    svc_wr        = 1'b0;
    svc_ok        = 1'b0;
    svc_addr      = '0;
    svc_data      = '0;
    wr_new        = wr_req;
    rd_new        = rd_req;
`ifdef GPU_HOST_PORT_ERR_CNT_EN
    // Both strobes share host_addr, so an out-of-range address flags each one.
    err_inc = addr_ok ? 2'd0 : (2'(wr_req) + 2'(rd_req));
`endif
    unique case (state)
      IDLE: begin
        if (pend_valid) begin
          svc           = 1'b1;
          svc_wr        = pend_wr;
          svc_addr      = pend_addr;
          svc_data      = pend_data;
          pend_valid_nx = 1'b0;
          slot_free     = 1'b1;
        end else if (wr_req) begin
          svc      = 1'b1;
          svc_wr   = 1'b1;
          svc_addr = host_addr;
          svc_data = host_wdata;
          wr_new   = 1'b0;
        end else if (rd_req) begin
          svc      = 1'b1;
          svc_addr = host_addr;
          rd_new   = 1'b0;
        end
      end
      WRITE:     state_nx = IDLE;
      READ_WAIT: begin
        if (wait_cnt == 3'(RAM_LATENCY - 1)) state_nx = READ_DONE;
        else wait_cnt_nx = wait_cnt + 3'd1;
      end
      READ_DONE: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase

    if (svc) begin
      svc_ok = in_range(svc_addr);
      if (svc_ok) ram_addr_nx = svc_addr[MEM_SIZE_BITS-1:0];
      if (svc_wr) begin
        state_nx    = WRITE;
        ram_wena_nx = svc_ok;
        if (svc_ok) ram_wdata_nx = svc_data;
      end else begin
        state_nx    = READ_WAIT;
        wait_cnt_nx = '0;
        cur_oor_nx  = !svc_ok;
      end
    end

    // Unserviced new requests: write claims the slot before read.
    if (wr_new) begin
      if (slot_free) begin
        pend_valid_nx = 1'b1;
        pend_wr_nx    = 1'b1;
        pend_addr_nx  = host_addr;
        pend_data_nx  = host_wdata;
        slot_free     = 1'b0;
      end else begin
`ifdef GPU_HOST_PORT_ERR_CNT_EN
        if (addr_ok) err_inc = err_inc + 2'd1;
`endif
      end
    end
    if (rd_new) begin
      if (slot_free) begin
        pend_valid_nx = 1'b1;
        pend_wr_nx    = 1'b0;
        pend_addr_nx  = host_addr;
        pend_data_nx  = host_wdata;
        slot_free     = 1'b0;
      end else begin
`ifdef GPU_HOST_PORT_ERR_CNT_EN
        if (addr_ok) err_inc = err_inc + 2'd1;
`endif
      end
    end
  end

  // Datapath registers: pending slot, wait counter, RAM port, read result.
  always_ff @(posedge GPU_CLK) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_wr    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      wait_cnt   <= '0;
      cur_oor    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wena   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      pend_valid <= pend_valid_nx;
      pend_wr    <= pend_wr_nx;
      pend_addr  <= pend_addr_nx;
      pend_data  <= pend_data_nx;
      wait_cnt   <= wait_cnt_nx;
      cur_oor    <= cur_oor_nx;
      ram_addr   <= ram_addr_nx;
      ram_wdata  <= ram_wdata_nx;
      ram_wena   <= ram_wena_nx;
      if (state == READ_DONE) rdata_q <= rd_value;
    end
  end

  // RAM data is valid during READ_DONE itself, so the result is passed
  // through in that cycle and held in rdata_q afterwards.
  assign rd_value    = cur_oor ? 8'hFF : ram_rdata;
  assign host_rdata  = (state == READ_DONE) ? rd_value : rdata_q;
  assign host_rd_rdy = (state == READ_DONE);
  assign busy        = (state != IDLE) || pend_valid;

`ifdef GPU_HOST_PORT_ERR_CNT_EN
  assign addr_ok = in_range(host_addr);
  assign err_sum = {1'b0, err_count} + {7'd0, err_inc};

  // Saturating count of out-of-range and dropped requests.
  always_ff @(posedge GPU_CLK) begin
    if (reset) err_count <= '0;
    else       err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_gpu_host_port.sv
// tb_gpu_host_port: directed checks of gpu_host_port with a 2-cycle RAM model.
module tb_gpu_host_port;
  localparam int unsigned MSB = 15;
  localparam int unsigned LAT = 2;
`ifdef GPU_HOST_PORT_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           GPU_CLK = 1'b0;
  logic           reset;
  logic           host_wr_ena, host_rd_req;
  logic [19:0]    host_addr;
  logic [7:0]     host_wdata, host_rdata, ram_wdata, ram_rdata, err_count;
  logic           host_rd_rdy, ram_wena, busy;
  logic [MSB-1:0] ram_addr;

  int tests = 0;
  int fails = 0;
  int rdy_cnt = 0;
  int base = 0;
  logic prev_rdy = 1'b0;

  logic [7:0] mem [0:(1<<MSB)-1];
  logic [7:0] pipe [0:LAT-1];

  gpu_host_port #(.MEM_SIZE_BITS(MSB), .RAM_LATENCY(LAT)) dut (
    .GPU_CLK(GPU_CLK), .reset(reset),
    .host_wr_ena(host_wr_ena), .host_rd_req(host_rd_req),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rd_rdy(host_rd_rdy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wena(ram_wena),
    .ram_rdata(ram_rdata), .busy(busy), .err_count(err_count)
  );

  always #4 GPU_CLK = ~GPU_CLK;

  // RAM model: address presented in cycle t returns data in cycle t+LAT.
  always @(posedge GPU_CLK) begin
    if (ram_wena) mem[ram_addr] <= ram_wdata;
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_err(input int k);
    return ERR_EN ? 32'(k) : 32'd0;
  endfunction

  task automatic cyc();
    @(posedge GPU_CLK);
    #1;
  endtask

  // Pulse counter and back-to-back rd_rdy watch.
  always @(negedge GPU_CLK) begin
    if (prev_rdy) check("rdy_back_to_back", 32'(host_rd_rdy), 32'd0);
    prev_rdy = host_rd_rdy;
    if (host_rd_rdy) rdy_cnt++;
  end

  initial begin
    reset = 1'b1; host_wr_ena = 1'b0; host_rd_req = 1'b0;
    host_addr = '0; host_wdata = '0;
    repeat (3) cyc();
    check("rst_rd_rdy", 32'(host_rd_rdy), 0);
    check("rst_wena", 32'(ram_wena), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_wdata", 32'(ram_wdata), 0);
    check("rst_rdata", 32'(host_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_count), 0);
    reset = 1'b0;
    cyc(); cyc();

    // Write 0xA5 to 0x10, then read it back.
    host_wr_ena = 1'b1; host_addr = 20'h00010; host_wdata = 8'hA5;
    cyc();
    check("wr_wena", 32'(ram_wena), 1);
    check("wr_addr", 32'(ram_addr), 32'h10);
    check("wr_wdata", 32'(ram_wdata), 32'hA5);
    check("wr_busy", 32'(busy), 1);
    host_wr_ena = 1'b0;
    cyc();
    check("wr_end_wena", 32'(ram_wena), 0);
    check("wr_end_busy", 32'(busy), 0);
    cyc(); cyc(); cyc();
    host_rd_req = 1'b1; host_addr = 20'h00010; base = rdy_cnt;
    cyc();
    host_rd_req = 1'b0;
    check("rd_busy", 32'(busy), 1);
    check("rd_addr", 32'(ram_addr), 32'h10);
    check("rd_early1", 32'(host_rd_rdy), 0);
    cyc();
    check("rd_early2", 32'(host_rd_rdy), 0);
    cyc();
    check("rd_rdy", 32'(host_rd_rdy), 1);
    check("rd_data", 32'(host_rdata), 32'hA5);
    cyc();
    check("rd_rdy_low", 32'(host_rd_rdy), 0);
    check("rd_hold", 32'(host_rdata), 32'hA5);
    check("rd_pulses", 32'(rdy_cnt - base), 1);
    check("rd_idle", 32'(busy), 0);

    // Out-of-range read.
    host_rd_req = 1'b1; host_addr = 20'h08000;
    cyc();
    host_rd_req = 1'b0;
    check("oor_rd_err", 32'(err_count), exp_err(1));
    cyc(); cyc();
    check("oor_rd_rdy", 32'(host_rd_rdy), 1);
    check("oor_rd_data", 32'(host_rdata), 32'hFF);
    cyc();

    // Simultaneous write and read of 0x20.
    host_wr_ena = 1'b1; host_rd_req = 1'b1; host_addr = 20'h00020; host_wdata = 8'h3C;
    base = rdy_cnt;
    cyc();
    host_wr_ena = 1'b0; host_rd_req = 1'b0;
    check("sim_wena", 32'(ram_wena), 1);
    check("sim_waddr", 32'(ram_addr), 32'h20);
    check("sim_wdata", 32'(ram_wdata), 32'h3C);
    cyc();
    check("sim_pend_busy", 32'(busy), 1);
    cyc(); cyc();
    check("sim_early", 32'(host_rd_rdy), 0);
    cyc();
    check("sim_rdy", 32'(host_rd_rdy), 1);
    check("sim_data", 32'(host_rdata), 32'h3C);
    cyc(); cyc(); cyc();
    check("sim_pulses", 32'(rdy_cnt - base), 1);
    check("sim_err", 32'(err_count), exp_err(1));

    // Read strobe held high for 20 cycles.
    host_rd_req = 1'b1; host_addr = 20'h00010; base = rdy_cnt;
    repeat (20) cyc();
    host_rd_req = 1'b0;
    cyc(); cyc(); cyc();
    check("hold_pulses", 32'(rdy_cnt - base), 1);
    check("hold_data", 32'(host_rdata), 32'hA5);

    // Write 0x77 to 0x40, then three reads while busy: third is dropped.
    host_wr_ena = 1'b1; host_addr = 20'h00040; host_wdata = 8'h77; base = rdy_cnt;
    cyc();
    host_wr_ena = 1'b0; host_rd_req = 1'b1; host_addr = 20'h00010;
    cyc();
    host_rd_req = 1'b0;
    cyc();
    host_rd_req = 1'b1; host_addr = 20'h00020;
    cyc();
    host_rd_req = 1'b0;
    cyc();
    host_rd_req = 1'b1; host_addr = 20'h00040;
    check("q3_first_rdy", 32'(host_rd_rdy), 1);
    check("q3_first_data", 32'(host_rdata), 32'hA5);
    cyc();
    host_rd_req = 1'b0;
    check("q3_err", 32'(err_count), exp_err(2));
    cyc(); cyc();
    check("q3_gap", 32'(host_rd_rdy), 0);
    cyc();
    check("q3_second_rdy", 32'(host_rd_rdy), 1);
    check("q3_second_data", 32'(host_rdata), 32'h3C);
    cyc();
    check("q3_idle", 32'(busy), 0);
    repeat (6) cyc();
    check("q3_pulses", 32'(rdy_cnt - base), 2);
    check("q3_hold", 32'(host_rdata), 32'h3C);

    // Out-of-range write must not alias onto 0x10.
    host_wr_ena = 1'b1; host_addr = 20'h08010; host_wdata = 8'h99;
    cyc();
    host_wr_ena = 1'b0;
    check("oor_wr_wena", 32'(ram_wena), 0);
    check("oor_wr_busy", 32'(busy), 1);
    check("oor_wr_err", 32'(err_count), exp_err(3));
    cyc(); cyc();
    host_rd_req = 1'b1; host_addr = 20'h00010;
    cyc();
    host_rd_req = 1'b0;
    cyc(); cyc();
    check("oor_wr_rdy", 32'(host_rd_rdy), 1);
    check("oor_wr_intact", 32'(host_rdata), 32'hA5);
    cyc();

    // Reset one cycle after a read request.
    host_rd_req = 1'b1; host_addr = 20'h00010; base = rdy_cnt;
    cyc();
    reset = 1'b1; host_rd_req = 1'b0;
    cyc();
    reset = 1'b0;
    check("abort_rdy", 32'(host_rd_rdy), 0);
    check("abort_wena", 32'(ram_wena), 0);
    check("abort_addr", 32'(ram_addr), 0);
    check("abort_wdata", 32'(ram_wdata), 0);
    check("abort_rdata", 32'(host_rdata), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_err", 32'(err_count), 0);
    repeat (5) cyc();
    check("abort_pulses", 32'(rdy_cnt - base), 0);

    // Strobe already high across reset release: no request until re-armed.
    reset = 1'b1; host_rd_req = 1'b1; host_addr = 20'h00010;
    cyc();
    reset = 1'b0; base = rdy_cnt;
    repeat (8) cyc();
    check("held_no_pulse", 32'(rdy_cnt - base), 0);
    check("held_busy", 32'(busy), 0);
    host_rd_req = 1'b0;
    cyc();
    host_rd_req = 1'b1;
    cyc();
    host_rd_req = 1'b0;
    cyc(); cyc();
    check("rearm_rdy", 32'(host_rd_rdy), 1);
    check("rearm_data", 32'(host_rdata), 32'hA5);
    cyc();
    check("rearm_pulses", 32'(rdy_cnt - base), 1);
    check("final_err", 32'(err_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpu_host_port.md
GPU_HOST_PORT -- requirements
Module: gpu_host_port

Interface
REQ-001 Parameter MEM_SIZE_BITS, default 15: width of the RAM address; valid host addresses are 0 to 2**MEM_SIZE_BITS-1.
REQ-002 Parameter RAM_LATENCY, default 2: cycles from ram_addr being presented to ram_rdata being valid; range 1-7.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 GPU_CLK  in  1  system clock, 125 MHz; all logic on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 host_wr_ena  in  1  host write strobe, level; its rising edge starts one write.
REQ-007 host_rd_req  in  1  host read strobe, level; its rising edge starts one read.
REQ-008 host_addr  in  20  host byte address.
REQ-009 host_wdata  in  8  host write data.
REQ-010 host_rdata  out  8  read result; holds its value until the next read completes.
REQ-011 host_rd_rdy  out  1  one-cycle pulse; host_rdata is valid in this cycle.
REQ-012 ram_addr  out  MEM_SIZE_BITS  RAM address.
REQ-013 ram_wdata  out  8  RAM write data.
REQ-014 ram_wena  out  1  RAM write enable, one cycle per write.
REQ-015 ram_rdata  in  8  RAM read data.
REQ-016 busy  out  1  high whenever the state is not IDLE or the pending slot is full.
REQ-017 err_count  out  8  count of out-of-range and dropped requests (see Configuration).

Function
REQ-018 Edge detect: each strobe is registered every cycle; a request exists in the cycle where the strobe is 1 and its registered copy is 0.
  - A strobe held high produces exactly one request.
REQ-019 Requests are captured together with host_addr and host_wdata from the same cycle.
REQ-020 Range check: a request is in range when host_addr < 2**MEM_SIZE_BITS.
REQ-021 States: IDLE, WRITE, READ_WAIT, READ_DONE.
REQ-022 IDLE with a write request in cycle N:
  - go to WRITE;
  - in cycle N+1, ram_wena=1 with the captured address and data;
  - return to IDLE at N+2.
REQ-023 Out-of-range write: WRITE state is entered, but ram_wena stays 0 and RAM is not modified.
REQ-024 IDLE with a read request in cycle N:
  - go to READ_WAIT and drive ram_addr with the captured address from N+1;
  - a 3-bit wait counter runs for RAM_LATENCY cycles;
  - then go to READ_DONE.
REQ-025 READ_DONE:
  - capture ram_rdata into host_rdata;
  - pulse host_rd_rdy=1 in that same cycle, i.e. cycle N+1+RAM_LATENCY;
  - return to IDLE.
REQ-026 Out-of-range read: same timing as an in-range read, but host_rdata=8'hFF.
REQ-027 Simultaneous read and write requests in IDLE: the write is serviced first; the read goes into the pending slot.
REQ-028 Pending slot: one entry holding type, address and data.
  - A request that arrives while not IDLE is stored there when the slot is empty.
  - In IDLE, the pending slot is serviced before any new request.
  - A new request arriving in that same cycle takes the slot.
REQ-029 A request arriving while the pending slot is full is dropped; no RAM access and no rd_rdy pulse result from it.
REQ-030 host_rd_rdy is never high for two consecutive cycles.
REQ-031 ram_wena and a read access are never active in the same cycle.
REQ-032 When not in WRITE, ram_wena=0; ram_addr holds its last value.

Reset
REQ-033 Reset forces all of the following in the next cycle:
  - state IDLE, pending slot empty, wait counter 0, edge registers 0;
  - host_rd_rdy=0, ram_wena=0, ram_addr=0, ram_wdata=0, host_rdata=0, busy=0, err_count=0.
REQ-034 Reset asserted mid-operation aborts the operation: no ram_wena pulse or rd_rdy pulse follows, and any pending request is discarded.
REQ-035 A strobe already high when reset deasserts produces no request until it goes low and high again.

Configuration
REQ-036 Macro GPU_HOST_PORT_ERR_CNT_EN.
  - Defined: err_count increments by 1 for each out-of-range request and each dropped request, and saturates at 8'hFF.
  - Not defined: err_count is constant 0 and no counter logic exists.
  - All other behaviour is identical with or without the macro.

Verification
REQ-037 Write, then read back:
  - Write addr 0x00010, data 0xA5 at cycle 0 -> ram_wena=1 at cycle 1 with ram_addr=0x0010.
  - Read the same address at cycle 5 -> host_rd_rdy at cycle 8 (RAM_LATENCY=2), host_rdata=0xA5.
REQ-038 Read addr 0x08000 (MEM_SIZE_BITS=15) -> host_rd_rdy after 3 cycles, host_rdata=0xFF; err_count=1 when the macro is defined.
REQ-039 Write and read strobes rise in the same cycle, addr 0x00020, data 0x3C:
  - the write occurs first;
  - the read then returns 0x3C;
  - exactly one rd_rdy pulse results.
REQ-040 Hold host_rd_req high for 20 cycles -> exactly one host_rd_rdy pulse.
REQ-041 Three reads issued on consecutive edges while busy:
  - the first two complete in order;
  - the third is dropped;
  - err_count increments by 1 when the macro is defined.
REQ-042 Assert reset one cycle after a read request:
  - no host_rd_rdy pulse occurs;
  - all outputs are 0 on the following cycle;
  - busy=0.
